// File: rtl/ddr_lane_dly_if.sv
// ddr_lane_dly_if: request handshake plus per-lane IOD delay-line controls and tap readback
interface ddr_lane_dly_if #(
  parameter int LANES = 2,
  parameter int TAP_W = 8,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
);
  logic REQ_VALID;
  logic REQ_READY;
  logic [LANE_W-1:0] REQ_LANE;
  logic [TAP_W-1:0] REQ_TAP;
  logic REQ_LOAD;
  logic [LANES-1:0] DELAY_LINE_LOAD;
  logic [LANES-1:0] DELAY_LINE_MOVE;
  logic [LANES-1:0] DELAY_LINE_DIRECTION;
  logic [LANES-1:0] DELAY_LINE_OUT_OF_RANGE;
  logic [LANES*TAP_W-1:0] CUR_TAP;
  logic BUSY;
  logic DONE;
  logic ERR;
  logic [15:0] STEP_CNT;
  modport master (
    output REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD, DELAY_LINE_OUT_OF_RANGE,
    input REQ_READY, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
    input CUR_TAP, BUSY, DONE, ERR, STEP_CNT
  );
  modport slave (
    input REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD, DELAY_LINE_OUT_OF_RANGE,
    output REQ_READY, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
    output CUR_TAP, BUSY, DONE, ERR, STEP_CNT
  );
endinterface

// File: rtl/ddr_lane_dly_ctrl.sv
// ddr_lane_dly_ctrl: steps one IOD lane's delay line to a target tap; DDR_LANE_DLY_STEP_CNT_EN adds a saturating STEP_CNT
module ddr_lane_dly_ctrl #(
  parameter int LANES = 2,
  parameter int TAP_W = 8,
  parameter int INIT_TAP = 1,
  parameter int MAX_TAP = 127,
  parameter int MOVE_GAP = 2
) (
  input logic FAB_CLK,
  input logic TX_SYNC_RST,
  ddr_lane_dly_if.slave bus
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GAP_W = $clog2(MOVE_GAP + 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT = 3'd2, CHECK = 3'd3, MOVE = 3'd4, FIN = 3'd5, FAIL = 3'd6;
  logic [2:0] state, nxt;
  logic [LANE_W-1:0] lane, lane_d;
  logic [TAP_W-1:0] target, cur;
  logic [GAP_W-1:0] gap;
  logic [LANES*TAP_W-1:0] taps;
  logic [LANES-1:0] dir, ld, mv, sel;
  logic moved, accept, bad, oor, hit, ready, busy, done, err;
  assign accept = bus.REQ_VALID && state == IDLE;
  assign bad = 32'(bus.REQ_TAP) > MAX_TAP || 32'(bus.REQ_LANE) >= LANES;
  assign lane_d = accept && !bad ? bus.REQ_LANE : lane;
  assign sel = LANES'(1) << lane_d;
  assign cur = taps[lane*TAP_W +: TAP_W];
  assign oor = bus.DELAY_LINE_OUT_OF_RANGE[lane];
  assign hit = cur == target;
  // CHECK doubles as the last idle cycle of each gap, so WAIT holds MOVE_GAP-1 cycles
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = !accept ? IDLE : bad ? FAIL : bus.REQ_LOAD ? LOAD : CHECK;
      LOAD, MOVE: nxt = MOVE_GAP > 1 ? WAIT : CHECK;
      WAIT: nxt = 32'(gap) >= MOVE_GAP - 2 ? CHECK : WAIT;
      CHECK: nxt = moved && oor ? FAIL : hit ? FIN : MOVE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state <= IDLE;
      lane <= '0;
      target <= '0;
      gap <= '0;
      moved <= 1'b0;
      taps <= {LANES{TAP_W'(INIT_TAP)}};
      dir <= '0;
      ld <= '0;
      mv <= '0;
      ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      gap <= state == WAIT ? gap + 1'b1 : '0;
      if (accept && !bad) begin
        lane <= bus.REQ_LANE;
        target <= bus.REQ_TAP;
        moved <= 1'b0;
      end
      if (state == LOAD) taps[lane*TAP_W +: TAP_W] <= TAP_W'(INIT_TAP);
      if (state == MOVE) begin
        taps[lane*TAP_W +: TAP_W] <= dir[lane] ? cur + TAP_W'(1) : cur - TAP_W'(1);
        moved <= 1'b1;
      end
      // the IOD flagged the step just taken as past its limit, so undo it
      if (state == CHECK && nxt == FAIL) taps[lane*TAP_W +: TAP_W] <= dir[lane] ? cur - TAP_W'(1) : cur + TAP_W'(1);
      if (state == CHECK && nxt == MOVE) dir[lane] <= target > cur;
      ld <= nxt == LOAD ? sel : '0;
      mv <= nxt == MOVE ? sel : '0;
      ready <= nxt == IDLE;
      busy <= nxt != IDLE;
      done <= nxt == FIN;
      err <= nxt == FAIL;
    end
  end
  assign bus.REQ_READY = ready;
  assign bus.DELAY_LINE_LOAD = ld;
  assign bus.DELAY_LINE_MOVE = mv;
  assign bus.DELAY_LINE_DIRECTION = dir;
  assign bus.CUR_TAP = taps;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.ERR = err;
`ifdef DDR_LANE_DLY_STEP_CNT_EN
  logic [15:0] step_cnt;
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) step_cnt <= '0;
    else if (state == MOVE && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
  end
  assign bus.STEP_CNT = step_cnt;
`else
  assign bus.STEP_CNT = '0;
`endif
endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// tb_ddr_lane_dly_ctrl: directed and random requests checked against a per-lane tap model
module tb_ddr_lane_dly_ctrl;
  localparam int LANES = 2, TAP_W = 8, INIT_TAP = 1, MAX_TAP = 127, MOVE_GAP = 2;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  ddr_lane_dly_if #(.LANES(LANES), .TAP_W(TAP_W)) bus ();
  ddr_lane_dly_ctrl #(.LANES(LANES), .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP), .MOVE_GAP(MOVE_GAP))
    dut (.FAB_CLK(clk), .TX_SYNC_RST(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int model[LANES];
  int steps = 0;
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int tap_of(input int ln);
    return int'(bus.CUR_TAP[ln*TAP_W +: TAP_W]);
  endfunction
  task automatic chk_steps();
`ifdef DDR_LANE_DLY_STEP_CNT_EN
    chk("step_cnt", bus.STEP_CNT, steps > 65535 ? 65535 : steps);
`else
    chk("step_cnt", bus.STEP_CNT, 0);
`endif
  endtask
  // one request: expected timing follows from 1+MOVE_GAP cycles per step
  task automatic run_req(input int ln, input int tp, input bit ld, input int oor_k);
    int start = ld ? INIT_TAP : model[ln];
    int n = tp > start ? tp - start : start - tp;
    bit bad = tp > MAX_TAP || ln >= LANES;
    bit up = tp > start;
    int period = 1 + MOVE_GAP;
    int first = ld ? 2 + MOVE_GAP : 2;
    int fail_k = (!bad && oor_k >= 1 && oor_k <= n) ? oor_k : 0;
    int exp_moves = bad ? 0 : (fail_k != 0 ? fail_k : n);
    int end_c = bad ? 1 : first + exp_moves * period;
    int oth = 1 - ln;
    int oth_tap = model[oth];
    int c = 0, mv_n = 0, ld_n = 0, stray = 0, done_c = -1, err_c = -1, bad_dir = 0, bad_time = 0;
    chk("ready_before", bus.REQ_READY, 1);
    @(negedge clk);
    bus.REQ_VALID = 1;
    bus.REQ_LANE = ln[0];
    bus.REQ_TAP = tp[TAP_W-1:0];
    bus.REQ_LOAD = ld;
    @(posedge clk);
    #1 bus.REQ_VALID = 0;
    while (done_c < 0 && err_c < 0 && c < 400) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("busy", bus.BUSY, 1);
      if (bus.DELAY_LINE_MOVE[ln]) begin
        mv_n++;
        if (c != first + (mv_n - 1) * period) bad_time++;
        if (bus.DELAY_LINE_DIRECTION[ln] !== up) bad_dir++;
        if (mv_n == oor_k) bus.DELAY_LINE_OUT_OF_RANGE[ln] = 1;
      end
      if (bus.DELAY_LINE_LOAD[ln]) begin
        ld_n++;
        if (c != 1) bad_time++;
      end
      if (((bus.DELAY_LINE_MOVE | bus.DELAY_LINE_LOAD) & ~(LANES'(1) << ln)) != 0) stray++;
      if (tap_of(oth) != oth_tap) stray++;
      if (bus.DONE) done_c = c;
      if (bus.ERR) err_c = c;
    end
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    chk("moves", mv_n, exp_moves);
    chk("loads", ld_n, (ld && !bad) ? 1 : 0);
    chk("pulse_time", bad_time, 0);
    chk("direction", bad_dir, 0);
    chk("other_lane", stray, 0);
    chk("done_cycle", done_c, (bad || fail_k != 0) ? -1 : end_c);
    chk("err_cycle", err_c, (bad || fail_k != 0) ? end_c : -1);
    if (!bad) model[ln] = fail_k != 0 ? (up ? start + fail_k - 1 : start - fail_k + 1) : tp;
    steps += exp_moves;
    @(negedge clk);
    chk("cur_tap", tap_of(ln), model[ln]);
    chk("ready_after", bus.REQ_READY, 1);
    chk_steps();
  endtask
  initial begin
    int ln, tp, k, mv_n, c, stray;
    bit ld;
    bus.REQ_VALID = 0;
    bus.REQ_LANE = '0;
    bus.REQ_TAP = '0;
    bus.REQ_LOAD = 0;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    foreach (model[i]) model[i] = INIT_TAP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.REQ_READY, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_tap", bus.CUR_TAP, {8'd1, 8'd1});
    chk("rst_pulses", {bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION, bus.DONE, bus.ERR}, 0);
    chk_steps();
    rst = 0;
    run_req(1, 4, 0, 0);
    chk("lane0_untouched", tap_of(0), 1);
    run_req(0, 5, 0, 0);
    run_req(0, 0, 1, 0);
    run_req(0, 1, 1, 0);
    run_req(0, 10, 0, 2);
    chk("oor_tap", tap_of(0), 2);
    run_req(1, 200, 0, 0);
    run_req(0, 4, 0, 0);
    for (int i = 0; i < 24; i++) begin
      ln = $urandom_range(0, LANES - 1);
      tp = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_TAP + 1, 255) : $urandom_range(0, 24);
      ld = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_req(ln, tp, ld, k);
    end
    run_req(0, MAX_TAP, 1, 0);
    run_req(0, MAX_TAP + 1, 0, 0);
    run_req(1, model[1] + 10, 0, 0);
    @(negedge clk);
    bus.REQ_VALID = 1;
    bus.REQ_LANE = '0;
    bus.REQ_TAP = 8'(model[0] > 20 ? 0 : 40);
    bus.REQ_LOAD = 0;
    @(posedge clk);
    #1 bus.REQ_VALID = 0;
    mv_n = 0;
    c = 0;
    while (mv_n < 2 && c < 50) begin
      @(negedge clk);
      c++;
      if (bus.DELAY_LINE_MOVE[0]) mv_n++;
    end
    chk("pre_reset_moves", mv_n, 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_ready", bus.REQ_READY, 1);
    stray = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.DONE || bus.ERR || bus.BUSY) stray++;
      @(negedge clk);
    end
    chk("post_rst_quiet", stray, 0);
    chk("post_rst_tap", bus.CUR_TAP, {8'd1, 8'd1});
    foreach (model[i]) model[i] = INIT_TAP;
    steps = 0;
    chk_steps();
    run_req(1, 3, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
